// File: rtl/bd_buffer_mc.sv
// ---------------------------------------------------------------------------
// bd_buffer_mc
//
// Multi-channel buffer-descriptor store for the PCIe DMA engine.
//
// Every channel owns DEPTH BD slots. The PCIe BD-fetch path fills slots
// (no backpressure). Each channel publishes a slot-valid bitmap and the
// address of its next fetch. req_recv drives a shared command port. That
// port can read a slot into the channel's output register, flush the
// channel, or set its fetch address. Each channel's output side uses a
// valid/ready handshake.
//
// Ports
//   user_clk / user_reset          clock, asynchronous active-high reset
//   m_axis_buffer_cmd_*            shared command port (tdata/tvalid/tready,
//                                  tdest selects the channel)
//                                    op = tdata[CMD_W-1:CMD_W-2]
//                                    00 READ slot tdata[SLOT_W-1:0]
//                                    01 FLUSH, new addr tdata[ADDR_W-1:0]
//                                    10 SET_ADDR tdata[ADDR_W-1:0]
//                                    11 reserved (accepted, ignored)
//   m_axis_bd_from_buffer_*        per-channel BD output, channel c at
//                                  [c*BD_W +: BD_W], per-channel valid/ready
//   m_from_pcie_bd_*               per-channel fill beats: slot (tuser),
//                                  data, valid, last-of-burst
//   bd_buf_addr                    per-channel next fetch address
//   bd_buf_valid                   per-channel slot-valid bitmap
//   bd_buf_fill_done               1-cycle pulse after a tlast beat
//   bd_buf_err                     1-cycle pulse on READ of an empty slot
//                                  or a fill into an occupied slot
// ---------------------------------------------------------------------------
module bd_buffer_mc #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int BD_W   = 256,
  parameter int ADDR_W = 23,
  parameter int CMD_W  = 44,
  parameter int CH_W   = 2
) (
  input  logic                       user_clk,
  input  logic                       user_reset,

  input  logic [CMD_W-1:0]           m_axis_buffer_cmd_tdata,
  input  logic                       m_axis_buffer_cmd_tvalid,
  output logic                       m_axis_buffer_cmd_tready,
  input  logic [CH_W-1:0]            m_axis_buffer_cmd_tdest,

  output logic [NUM_CH*BD_W-1:0]     m_axis_bd_from_buffer_tdata,
  output logic [NUM_CH-1:0]          m_axis_bd_from_buffer_tvalid,
  input  logic [NUM_CH-1:0]          m_axis_bd_from_buffer_tready,

  input  logic [NUM_CH*$clog2(DEPTH)-1:0] m_from_pcie_bd_tuser,
  input  logic [NUM_CH*BD_W-1:0]     m_from_pcie_bd_tdata,
  input  logic [NUM_CH-1:0]          m_from_pcie_bd_tvalid,
  input  logic [NUM_CH-1:0]          m_from_pcie_bd_tlast,

  output logic [NUM_CH*ADDR_W-1:0]   bd_buf_addr,
  output logic [NUM_CH*DEPTH-1:0]    bd_buf_valid,
  output logic [NUM_CH-1:0]          bd_buf_fill_done,
  output logic [NUM_CH-1:0]          bd_buf_err
);

  localparam int SLOT_W = $clog2(DEPTH);

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_FLUSH    = 2'b01;
  localparam logic [1:0] OP_SET_ADDR = 2'b10;

  // Each fill beat advances the fetch address by one BD, in bytes.
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BD_W / 8);

  // ------------------------------------------------------------------
  // Command decode (shared by all channels)
  // ------------------------------------------------------------------
  logic [1:0]        cmd_op;
  logic [SLOT_W-1:0] cmd_slot;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_fire;
  logic              sel_busy;
  logic [NUM_CH-1:0] out_valid;

  assign cmd_op   = m_axis_buffer_cmd_tdata[CMD_W-1 -: 2];
  assign cmd_slot = m_axis_buffer_cmd_tdata[SLOT_W-1:0];
  assign cmd_addr = m_axis_buffer_cmd_tdata[ADDR_W-1:0];

  // Middle command bits carry no meaning for any opcode.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^m_axis_buffer_cmd_tdata;

  // A READ may only be taken when the target output register is free or
  // is being drained this cycle. The drain path makes back-to-back
  // outputs possible with no bubble. A tdest beyond NUM_CH matches no
  // channel, so it is never busy and the command is swallowed.
  always_comb begin
    sel_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(m_axis_buffer_cmd_tdest) == c) begin
        sel_busy = out_valid[c] && !m_axis_bd_from_buffer_tready[c];
      end
    end
  end

  // Holding tready low while reset is asserted keeps the
  // requester from handing over a command that would be lost.
  assign m_axis_buffer_cmd_tready = !user_reset && !((cmd_op == OP_READ) && sel_busy);
  assign cmd_fire = m_axis_buffer_cmd_tvalid && m_axis_buffer_cmd_tready;

  // ------------------------------------------------------------------
  // Per-channel state
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BD_W-1:0]   storage [DEPTH];
      logic [DEPTH-1:0]  valid_reg, valid_next;
      logic [ADDR_W-1:0] addr_reg, addr_next;
      logic              out_valid_reg, out_valid_next;
      logic [BD_W-1:0]   out_data_reg;
      logic              fill_done_reg, fill_done_next;
      logic              err_reg, err_next;

      logic              cmd_hit;
      logic              do_read, do_flush, do_set_addr, read_ok;
      logic              fill;
      logic              fill_last;
      logic [SLOT_W-1:0] fill_slot;
      logic [BD_W-1:0]   fill_data;
      logic              out_ready;

      assign fill      = m_from_pcie_bd_tvalid[gi];
      assign fill_last = m_from_pcie_bd_tlast[gi];
      assign fill_slot = m_from_pcie_bd_tuser[gi*SLOT_W +: SLOT_W];
      assign fill_data = m_from_pcie_bd_tdata[gi*BD_W +: BD_W];
      assign out_ready = m_axis_bd_from_buffer_tready[gi];

      assign cmd_hit     = cmd_fire && (int'(m_axis_buffer_cmd_tdest) == gi);
      assign do_read     = cmd_hit && (cmd_op == OP_READ);
      assign do_flush    = cmd_hit && (cmd_op == OP_FLUSH);
      assign do_set_addr = cmd_hit && (cmd_op == OP_SET_ADDR);
      // Validity is judged on the state before this cycle's fill, so a
      // READ racing a fill into an empty slot is an error.
      assign read_ok     = do_read && valid_reg[cmd_slot];

      always_comb begin
        valid_next     = valid_reg;
        addr_next      = addr_reg;
        out_valid_next = out_valid_reg;
        fill_done_next = fill && fill_last;
        // All error causes fold into a single pulse.
        err_next       = (do_read && !valid_reg[cmd_slot]) ||
                         (fill && valid_reg[fill_slot]);

        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
        end

        if (read_ok) begin
          out_valid_next       = 1'b1;
          valid_next[cmd_slot] = 1'b0;
        end

        // The fill is applied after the read clear, so a fill into the
        // slot being read leaves that slot valid with the new data.
        if (fill) begin
          valid_next[fill_slot] = 1'b1;
          addr_next             = addr_reg + ADDR_STEP;
        end

        // Address commands override the fill's bookkeeping in the same
        // cycle. The beat's data still lands in storage.
        if (do_flush) begin
          valid_next = '0;
          addr_next  = cmd_addr;
        end else if (do_set_addr) begin
          addr_next = cmd_addr;
        end
      end

      always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
          valid_reg     <= '0;
          addr_reg      <= '0;
          out_valid_reg <= 1'b0;
          fill_done_reg <= 1'b0;
          err_reg       <= 1'b0;
        end else begin
          valid_reg     <= valid_next;
          addr_reg      <= addr_next;
          out_valid_reg <= out_valid_next;
          fill_done_reg <= fill_done_next;
          err_reg       <= err_next;
        end
      end

      // BD storage: plain RAM, written by the fill path and read
      // synchronously into the output register. A same-slot read and
      // write in one cycle return the old contents.
      always_ff @(posedge user_clk) begin
        if (fill) begin
          storage[fill_slot] <= fill_data;
        end
      end

      // The output data needs no reset because out_valid_reg qualifies it.
      // read_ok only fires when the register is free or draining, so
      // the data stays stable while valid is held.
      always_ff @(posedge user_clk) begin
        if (read_ok) begin
          out_data_reg <= storage[cmd_slot];
        end
      end

      assign out_valid[gi]                                = out_valid_reg;
      assign m_axis_bd_from_buffer_tvalid[gi]             = out_valid_reg;
      assign m_axis_bd_from_buffer_tdata[gi*BD_W +: BD_W] = out_data_reg;
      assign bd_buf_addr[gi*ADDR_W +: ADDR_W]             = addr_reg;
      assign bd_buf_valid[gi*DEPTH +: DEPTH]              = valid_reg;
      assign bd_buf_fill_done[gi]                         = fill_done_reg;
      assign bd_buf_err[gi]                               = err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bd_buffer_mc.sv
module tb_bd_buffer_mc;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int BD_W   = 256;
  localparam int ADDR_W = 23;
  localparam int CMD_W  = 44;
  localparam int CH_W   = 2;
  localparam int SLOT_W = 4;

  logic                      clk;
  logic                      rst;
  logic [CMD_W-1:0]          cmd_tdata;
  logic                      cmd_tvalid;
  logic                      cmd_tready;
  logic [CH_W-1:0]           cmd_tdest;
  logic [NUM_CH*BD_W-1:0]    out_tdata;
  logic [NUM_CH-1:0]         out_tvalid;
  logic [NUM_CH-1:0]         out_tready;
  logic [NUM_CH*SLOT_W-1:0]  fill_tuser;
  logic [NUM_CH*BD_W-1:0]    fill_tdata;
  logic [NUM_CH-1:0]         fill_tvalid;
  logic [NUM_CH-1:0]         fill_tlast;
  logic [NUM_CH*ADDR_W-1:0]  buf_addr;
  logic [NUM_CH*DEPTH-1:0]   buf_valid;
  logic [NUM_CH-1:0]         fill_done;
  logic [NUM_CH-1:0]         buf_err;

  bd_buffer_mc #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .BD_W(BD_W),
    .ADDR_W(ADDR_W), .CMD_W(CMD_W), .CH_W(CH_W)
  ) dut (
    .user_clk                     (clk),
    .user_reset                   (rst),
    .m_axis_buffer_cmd_tdata      (cmd_tdata),
    .m_axis_buffer_cmd_tvalid     (cmd_tvalid),
    .m_axis_buffer_cmd_tready     (cmd_tready),
    .m_axis_buffer_cmd_tdest      (cmd_tdest),
    .m_axis_bd_from_buffer_tdata  (out_tdata),
    .m_axis_bd_from_buffer_tvalid (out_tvalid),
    .m_axis_bd_from_buffer_tready (out_tready),
    .m_from_pcie_bd_tuser         (fill_tuser),
    .m_from_pcie_bd_tdata         (fill_tdata),
    .m_from_pcie_bd_tvalid        (fill_tvalid),
    .m_from_pcie_bd_tlast         (fill_tlast),
    .bd_buf_addr                  (buf_addr),
    .bd_buf_valid                 (buf_valid),
    .bd_buf_fill_done             (fill_done),
    .bd_buf_err                   (buf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_cnt   [NUM_CH];
  int fd_cnt    [NUM_CH];
  int last_xfer [NUM_CH];
  int prev_xfer [NUM_CH];
  logic [BD_W-1:0] exp_q [NUM_CH][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BD_W-1:0] act, input logic [BD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DEPTH-1:0] ch_valid(input int c);
    return buf_valid[c*DEPTH +: DEPTH];
  endfunction

  function automatic logic [ADDR_W-1:0] ch_addr(input int c);
    return buf_addr[c*ADDR_W +: ADDR_W];
  endfunction

  // Monitor: pops the scoreboard whenever a BD is handed over, counts pulses.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (buf_err[c])   err_cnt[c]++;
      if (fill_done[c]) fd_cnt[c]++;
      if (out_tvalid[c] && out_tready[c]) begin
        if (exp_q[c].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bd ch%0d: got %0h, required no output", c, out_tdata[c*BD_W +: BD_W]);
        end else begin
          logic [BD_W-1:0] e;
          e = exp_q[c].pop_front();
          $display("bd out ch%0d data %0h (cycle %0d)", c, out_tdata[c*BD_W +: BD_W], cyc);
          check($sformatf("bd_ch%0d", c), out_tdata[c*BD_W +: BD_W], e);
        end
        prev_xfer[c] = last_xfer[c];
        last_xfer[c] = cyc;
      end
    end
  end

  // One fill beat; entered and left at posedge+1.
  task automatic fill(input int c, input int slot, input logic [BD_W-1:0] data, input logic last);
    fill_tvalid[c] = 1'b1;
    fill_tlast[c]  = last;
    fill_tuser[c*SLOT_W +: SLOT_W] = SLOT_W'(slot);
    fill_tdata[c*BD_W +: BD_W]     = data;
    $display("fill ch%0d slot %0d data %0h last %0b", c, slot, data, last);
    @(posedge clk); #1;
    fill_tvalid[c] = 1'b0;
    fill_tlast[c]  = 1'b0;
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input logic [41:0] payload);
    return {op, payload};
  endfunction

  // Issue one command, waiting at most 20 cycles for tready.
  task automatic send_cmd(input int c, input logic [1:0] op, input logic [41:0] payload);
    logic acc;
    acc = 1'b0;
    cmd_tvalid = 1'b1;
    cmd_tdest  = CH_W'(c);
    cmd_tdata  = mk_cmd(op, payload);
    $display("cmd ch%0d op %0d payload %0h", c, op, payload);
    for (int i = 0; i < 20; i++) begin
      #3;
      acc = cmd_tready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_timeout ch%0d: got tready 0, required 1 within 20 cycles", c);
    end
    cmd_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      err_cnt[c] = 0; fd_cnt[c] = 0; last_xfer[c] = 0; prev_xfer[c] = 0;
    end
    rst = 1'b1;
    cmd_tdata = '0; cmd_tvalid = 1'b0; cmd_tdest = '0;
    out_tready = '1;
    fill_tuser = '0; fill_tdata = '0; fill_tvalid = '0; fill_tlast = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_tready", BD_W'(cmd_tready), '0);
    check("rst_out_tvalid", BD_W'(out_tvalid), '0);
    check("rst_valid",      BD_W'(buf_valid), '0);
    check("rst_addr",       BD_W'(buf_addr), '0);
    check("rst_fill_done",  BD_W'(fill_done), '0);
    check("rst_err",        BD_W'(buf_err), '0);
    rst = 1'b0;
    idle(1);

    // Fill ch1 slots 0..3
    for (int s = 0; s < 4; s++) fill(1, s, BD_W'(8'hA0 + s), s == 3);
    idle(1);
    check("fill_valid_ch1", BD_W'(ch_valid(1)), BD_W'(16'h000F));
    check("fill_addr_ch1",  BD_W'(ch_addr(1)),  BD_W'(23'h80));
    check("fill_done_ch1",  BD_W'(fd_cnt[1]),   BD_W'(1));

    // READ ch1 slot 2
    exp_q[1].push_back(BD_W'(8'hA2));
    send_cmd(1, 2'b00, 42'd2);
    check("read_tvalid_ch1", BD_W'(out_tvalid[1]), BD_W'(1));
    idle(2);
    check("read_valid_ch1", BD_W'(ch_valid(1)), BD_W'(16'h000B));
    check("read_err_ch1",   BD_W'(err_cnt[1]),  BD_W'(0));

    // Backpressure: output pending, second READ stalls, then no-bubble drain
    out_tready[1] = 1'b0;
    exp_q[1].push_back(BD_W'(8'hA0));
    send_cmd(1, 2'b00, 42'd0);
    idle(2);
    exp_q[1].push_back(BD_W'(8'hA1));
    cmd_tvalid = 1'b1; cmd_tdest = 2'd1; cmd_tdata = mk_cmd(2'b00, 42'd1);
    $display("cmd ch1 op 0 payload 1 (against stalled output)");
    #3;
    check("stall_tready_a", BD_W'(cmd_tready), '0);
    @(posedge clk); #1; #3;
    check("stall_tready_b", BD_W'(cmd_tready), '0);
    @(posedge clk); #1;
    out_tready[1] = 1'b1;
    #3;
    check("drain_tready", BD_W'(cmd_tready), BD_W'(1));
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
    idle(2);
    check("no_bubble_gap", BD_W'(last_xfer[1] - prev_xfer[1]), BD_W'(1));
    check("stall_q_empty", BD_W'(exp_q[1].size()), '0);
    check("stall_valid_ch1", BD_W'(ch_valid(1)), BD_W'(16'h0008));

    // READ of an invalid slot, and fill into an occupied slot
    send_cmd(0, 2'b00, 42'd7);
    idle(2);
    check("inv_read_err_ch0", BD_W'(err_cnt[0]), BD_W'(1));
    check("inv_read_tvalid",  BD_W'(out_tvalid[0]), '0);
    fill(1, 3, BD_W'(8'hB3), 1'b0);
    idle(1);
    check("overwrite_err_ch1", BD_W'(err_cnt[1]), BD_W'(1));
    exp_q[1].push_back(BD_W'(8'hB3));
    send_cmd(1, 2'b00, 42'd3);
    idle(2);
    check("overwrite_valid_ch1", BD_W'(ch_valid(1)), '0);
    check("overwrite_addr_ch1",  BD_W'(ch_addr(1)),  BD_W'(23'hA0));

    // FLUSH + fill in the same cycle
    fill(2, 0, BD_W'(8'hC0), 1'b0);
    fill_tvalid[2] = 1'b1; fill_tuser[2*SLOT_W +: SLOT_W] = 4'd5; fill_tdata[2*BD_W +: BD_W] = BD_W'(8'hC5);
    cmd_tvalid = 1'b1; cmd_tdest = 2'd2; cmd_tdata = mk_cmd(2'b01, 42'h100);
    $display("cmd ch2 op 1 payload 100 with fill slot 5");
    #3;
    check("flush_tready", BD_W'(cmd_tready), BD_W'(1));
    @(posedge clk); #1;
    cmd_tvalid = 1'b0; fill_tvalid[2] = 1'b0;
    idle(1);
    check("flush_valid_ch2", BD_W'(ch_valid(2)), '0);
    check("flush_addr_ch2",  BD_W'(ch_addr(2)),  BD_W'(23'h100));
    check("flush_err_ch2",   BD_W'(err_cnt[2]),  '0);

    // SET_ADDR + fill in the same cycle, then address wrap
    fill_tvalid[3] = 1'b1; fill_tuser[3*SLOT_W +: SLOT_W] = 4'd0; fill_tdata[3*BD_W +: BD_W] = BD_W'(8'hD0);
    cmd_tvalid = 1'b1; cmd_tdest = 2'd3; cmd_tdata = mk_cmd(2'b10, 42'h7FFFE0);
    $display("cmd ch3 op 2 payload 7fffe0 with fill slot 0");
    @(posedge clk); #1;
    cmd_tvalid = 1'b0; fill_tvalid[3] = 1'b0;
    check("setaddr_addr_ch3",  BD_W'(ch_addr(3)),  BD_W'(23'h7FFFE0));
    check("setaddr_valid_ch3", BD_W'(ch_valid(3)), BD_W'(16'h0001));
    fill(3, 1, BD_W'(8'hD1), 1'b1);
    check("wrap_addr_ch3", BD_W'(ch_addr(3)), '0);
    exp_q[3].push_back(BD_W'(8'hD1));
    send_cmd(3, 2'b00, 42'd1);
    idle(2);
    check("wrap_valid_ch3", BD_W'(ch_valid(3)), BD_W'(16'h0001));

    // READ and fill of the same slot in one cycle: old data out, new data kept
    fill(0, 4, BD_W'(8'hE0), 1'b0);
    exp_q[0].push_back(BD_W'(8'hE0));
    fill_tvalid[0] = 1'b1; fill_tuser[0 +: SLOT_W] = 4'd4; fill_tdata[0 +: BD_W] = BD_W'(8'hE4);
    cmd_tvalid = 1'b1; cmd_tdest = 2'd0; cmd_tdata = mk_cmd(2'b00, 42'd4);
    $display("cmd ch0 op 0 payload 4 with fill slot 4");
    @(posedge clk); #1;
    cmd_tvalid = 1'b0; fill_tvalid[0] = 1'b0;
    check("race_valid_ch0", BD_W'(ch_valid(0)), BD_W'(16'h0010));
    idle(1);
    exp_q[0].push_back(BD_W'(8'hE4));
    send_cmd(0, 2'b00, 42'd4);
    idle(2);
    check("race_reread_valid_ch0", BD_W'(ch_valid(0)), '0);

    // Reserved opcode does nothing
    send_cmd(0, 2'b11, 42'h55);
    idle(1);
    check("reserved_addr_ch0", BD_W'(ch_addr(0)), BD_W'(23'h40));

    // Reset in the middle of a burst with an output pending
    out_tready[0] = 1'b0;
    fill(0, 9, BD_W'(8'hF9), 1'b0);
    send_cmd(0, 2'b00, 42'd9);
    check("pre_rst_tvalid_ch0", BD_W'(out_tvalid[0]), BD_W'(1));
    fill_tvalid[1] = 1'b1; fill_tuser[1*SLOT_W +: SLOT_W] = 4'd8; fill_tdata[1*BD_W +: BD_W] = BD_W'(8'h18);
    @(posedge clk); #1;
    fill_tuser[1*SLOT_W +: SLOT_W] = 4'd9; fill_tlast[1] = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tvalid",     BD_W'(out_tvalid), '0);
    check("midrst_valid",      BD_W'(buf_valid),  '0);
    check("midrst_addr",       BD_W'(buf_addr),   '0);
    check("midrst_cmd_tready", BD_W'(cmd_tready), '0);
    check("midrst_fill_done",  BD_W'(fill_done),  '0);
    fill_tvalid = '0; fill_tlast = '0; out_tready = '1;
    idle(2);
    rst = 1'b0;
    idle(2);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("final_q_empty_ch%0d", c), BD_W'(exp_q[c].size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bd_buffer_mc.md
Name: bd_buffer_mc

Overview:
Parametrised multi-channel buffer-descriptor (BD) store for the PCIe DMA engine.
- Each channel (S2C/C2S pairs, NUM_CH total) holds DEPTH BD slots, filled by the PCIe BD-fetch path.
- Each channel publishes a slot-valid bitmap and a next-fetch address to req_recv.
- On command from req_recv, the block returns BDs to the response queue.
- Compared with the fixed 4-channel version, it adds command backpressure, output-side ready handshaking, flush/set-address commands, fill-done and error reporting.

Parameters:
NUM_CH, 4, number of DMA channels (1..16)
DEPTH, 16, BD slots per channel (power of 2, 2..64); SLOT_W = clog2(DEPTH)
BD_W, 256, BD width in bits
ADDR_W, 23, fetch-address width
CMD_W, 44, command width (must be >= ADDR_W+2 and >= SLOT_W+2)
CH_W, 2, command tdest width (clog2(NUM_CH), minimum 1)

Ports:
user_clk  in  1  clock
user_reset  in  1  asynchronous active-high reset
m_axis_buffer_cmd_tdata  in  CMD_W  command
m_axis_buffer_cmd_tvalid  in  1  command valid
m_axis_buffer_cmd_tready  out  1  command accepted
m_axis_buffer_cmd_tdest  in  CH_W  target channel
m_axis_bd_from_buffer_tdata  out  NUM_CH*BD_W  BD to response queue, channel c at [c*BD_W +: BD_W]
m_axis_bd_from_buffer_tvalid  out  NUM_CH  per-channel BD valid
m_axis_bd_from_buffer_tready  in  NUM_CH  per-channel BD ready
m_from_pcie_bd_tuser  in  NUM_CH*SLOT_W  destination slot per channel
m_from_pcie_bd_tdata  in  NUM_CH*BD_W  BD beat per channel
m_from_pcie_bd_tvalid  in  NUM_CH  beat valid (no backpressure)
m_from_pcie_bd_tlast  in  NUM_CH  last BD of a fetch burst
bd_buf_addr  out  NUM_CH*ADDR_W  per-channel next fetch address
bd_buf_valid  out  NUM_CH*DEPTH  per-channel slot-valid bitmap
bd_buf_fill_done  out  NUM_CH  1-cycle pulse after a tlast beat
bd_buf_err  out  NUM_CH  1-cycle pulse on a per-channel error

Behaviour:
- Reset (async assert, sync release): all valid bits 0, addr 0, output tvalid 0, fill_done 0, err 0, cmd_tready 0 during reset. The output tdata value at reset is don't-care.
- Command opcode is cmd[CMD_W-1:CMD_W-2]. A command transfers when tvalid && tready.
  - 00 READ slot = cmd[SLOT_W-1:0]:
    - If the slot is valid: latch storage[slot] into the channel output register; output tvalid rises the next cycle (1-cycle latency); the slot's valid bit clears.
    - If the slot is invalid: no output; bd_buf_err[ch] pulses the next cycle.
  - 01 FLUSH: clear all valid bits of the channel; addr <= cmd[ADDR_W-1:0]. A pending output register is not affected.
  - 10 SET_ADDR: addr <= cmd[ADDR_W-1:0]; valid bits unchanged.
  - 11: reserved; accepted and ignored.
- tdest >= NUM_CH: the command is accepted with no effect.
- cmd_tready = !out_tvalid[tdest] || out_tready[tdest]. This is evaluated for READ only; FLUSH, SET_ADDR and reserved commands are always ready (outside reset).
- Output handshake: tvalid holds and tdata is stable until tready. A READ accepted in the same cycle as a drain gives back-to-back output with no bubble.
- Fill, per channel, on each tvalid beat:
  - storage[tuser] <= tdata; valid[tuser] <= 1; addr <= addr + BD_W/8, wrapping mod 2^ADDR_W.
  - A beat into an already-valid slot overwrites the data and pulses err.
  - tlast beat -> fill_done pulses the next cycle.
- Simultaneous events, same channel, same cycle:
  - Fill into slot S and READ of S: the output carries the old data if S was valid; S ends valid with the new data. If S was invalid, READ errors and S ends valid.
  - FLUSH and fill beat: the flush wins. Valid bits are all 0 and addr = the flush value; the beat's data is written but its valid bit and addr increment are dropped.
  - SET_ADDR and fill beat: the SET_ADDR value wins; no increment that cycle.
  - Multiple err causes in one cycle produce a single pulse.
- Channels are fully independent; only the command port is shared.
- Reset mid-operation: pending outputs are lost and all state returns to reset values immediately.

Test Plan:
- Fill ch1 slots 0..3 with tdata=0xA0..0xA3, tlast on slot 3 -> bd_buf_valid ch1 = 16'h000F; addr ch1 = 0x80; fill_done[1] pulses once.
- READ ch1 slot 2 with tready=1 -> tvalid[1] one cycle later with data 0xA2; valid = 16'h000B; no err.
- Hold tready[1]=0 with an output pending, then issue READ ch1 -> cmd_tready=0 and the command is stalled. Raise tready -> output drains and the new BD appears the next cycle with no bubble.
- READ an invalid slot 7 on ch0 -> no tvalid; bd_buf_err[0] pulses once. Fill into a valid slot -> err pulses and the data is overwritten.
- Same cycle: FLUSH ch2 addr=0x100 plus a fill beat to slot 5 -> valid ch2 = 0; addr = 0x100.
- With addr=0x7FFFE0, fill one beat -> addr wraps to 0x000000. Assert reset mid-burst -> all outputs return to reset values at once.
